// File: rtl/multi_way_traffic_controller_if.sv
// Lamp/request bundle between the traffic controller and its environment.
// The controller takes the slave side; the tick source and lamp drivers take the master side.
interface multi_way_traffic_controller_if #(
  parameter int N_DIR = 2
);
  localparam int DIR_W = $clog2(N_DIR);

  logic             tick;
  logic             flash;
  logic [N_DIR-1:0] ped_req;
  logic [N_DIR-1:0] Red;
  logic [N_DIR-1:0] Green;
  logic [N_DIR-1:0] Yellow;
  logic [N_DIR-1:0] Walk;
  logic [DIR_W-1:0] active_dir;

  modport master (
    output tick, flash, ped_req,
    input  Red, Green, Yellow, Walk, active_dir
  );

  modport slave (
    input  tick, flash, ped_req,
    output Red, Green, Yellow, Walk, active_dir
  );
endinterface

// File: rtl/multi_way_traffic_controller.sv
// Round-robin N-approach traffic controller: GREEN -> YELLOW -> ALL-RED per approach,
// with latched pedestrian WALK requests and a flashing-yellow override. Moore outputs.
module multi_way_traffic_controller #(
  parameter int N_DIR        = 2,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2
) (
  input logic clk,
  input logic reset,
  multi_way_traffic_controller_if.slave bus
);

  localparam int DIR_W     = $clog2(N_DIR);
  localparam int MAX_TICKS = (GREEN_TICKS > YELLOW_TICKS)
                           ? ((GREEN_TICKS > ALLRED_TICKS) ? GREEN_TICKS : ALLRED_TICKS)
                           : ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS);
  localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [TIMER_W-1:0] GREEN_LOAD  = TIMER_W'(GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_TICKS - 1);
  localparam logic [DIR_W-1:0]   LAST_DIR    = DIR_W'(N_DIR - 1);

  typedef enum logic [1:0] {
    S_ALLRED,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_t;

  state_t             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [N_DIR-1:0]   pending_q, pending_d;
  logic               walk_q, walk_d;
  logic               phase_q, phase_d;

  logic [N_DIR-1:0]   dir_onehot;
  logic [N_DIR-1:0]   req_now;
  logic               expire;

  assign dir_onehot = N_DIR'(1) << dir_q;
  assign req_now    = pending_q | bus.ped_req;
  assign expire     = bus.tick && (timer_q == '0);

  // NOTE: state registers use non-blocking assignments so every register samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ALLRED;
      dir_q     <= '0;
      timer_q   <= ALLRED_LOAD;
      pending_q <= '0;
      walk_q    <= 1'b0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      walk_q    <= walk_d;
      phase_q   <= phase_d;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path through the
  // case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    pending_d = req_now;
    walk_d    = walk_q;
    phase_d   = phase_q;

    if (bus.flash) begin
      // Entering the override starts with the yellow lamps lit.
      state_d = S_FLASH;
      if (state_q != S_FLASH) begin
        phase_d = 1'b1;
      end else if (bus.tick) begin
        phase_d = ~phase_q;
      end
    end else if (state_q == S_FLASH) begin
      state_d = S_ALLRED;
      dir_d   = '0;
      timer_d = ALLRED_LOAD;
    end else if (bus.tick) begin
      if (!expire) begin
        timer_d = timer_q - TIMER_W'(1);
      end else begin
        unique case (state_q)
          S_ALLRED: begin
            // A request arriving on the entry edge is served now rather than re-latched.
            state_d   = S_GREEN;
            timer_d   = GREEN_LOAD;
            walk_d    = |(req_now & dir_onehot);
            pending_d = req_now & ~dir_onehot;
          end
          S_GREEN: begin
            state_d = S_YELLOW;
            timer_d = YELLOW_LOAD;
          end
          S_YELLOW: begin
            state_d = S_ALLRED;
            timer_d = ALLRED_LOAD;
            dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
          end
          default: begin
            state_d = S_ALLRED;
            timer_d = ALLRED_LOAD;
          end
        endcase
      end
    end
  end

  logic [N_DIR-1:0] red, green, yellow, walk;

  always_comb begin
    red    = '0;
    green  = '0;
    yellow = '0;
    walk   = '0;
    unique case (state_q)
      S_ALLRED: red = '1;
      S_GREEN: begin
        red   = ~dir_onehot;
        green = dir_onehot;
        walk  = walk_q ? dir_onehot : '0;
      end
      S_YELLOW: begin
        red    = ~dir_onehot;
        yellow = dir_onehot;
      end
      S_FLASH: yellow = {N_DIR{phase_q}};
      default: red = '1;
    endcase
  end

  assign bus.Red        = red;
  assign bus.Green      = green;
  assign bus.Yellow     = yellow;
  assign bus.Walk       = walk;
  assign bus.active_dir = dir_q;

endmodule

// File: tb/tb_multi_way_traffic_controller.sv
// Randomised scoreboard bench for multi_way_traffic_controller, running 2- and 3-approach
// instances side by side against a tick-counting reference model.
module tb_multi_way_traffic_controller;

  localparam int G = 4;
  localparam int Y = 2;
  localparam int A = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multi_way_traffic_controller_if #(.N_DIR(2)) if2 ();
  multi_way_traffic_controller_if #(.N_DIR(3)) if3 ();

  multi_way_traffic_controller #(
    .N_DIR(2), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A)
  ) dut2 (.clk(clk), .reset(reset), .bus(if2));

  multi_way_traffic_controller #(
    .N_DIR(3), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A)
  ) dut3 (.clk(clk), .reset(reset), .bus(if3));

  // Model phases: 0 all-red, 1 green, 2 yellow, 3 flashing.
  typedef struct {
    int       kind;
    int       dir;
    int       left;   // ticks remaining in the current phase, including this one
    bit [7:0] pend;
    bit       walk;
    bit       ph;
  } model_t;

  typedef struct {
    logic [7:0] red, green, yellow, walk, dir;
  } lamps_t;

  typedef struct {
    lamps_t l2;
    lamps_t l3;
  } exp_t;

  exp_t   sb[$];
  model_t m2, m3;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic model_t reset_model();
    model_t m;
    m.kind = 0; m.dir = 0; m.left = A; m.pend = '0; m.walk = 1'b0; m.ph = 1'b0;
    return m;
  endfunction

  function automatic model_t step(input model_t mi, input int n, input bit rst,
                                 input bit tk, input bit fl, input bit [7:0] pr);
    model_t   m = mi;
    bit [7:0] mask = 8'((1 << n) - 1);
    if (rst) return reset_model();
    m.pend = m.pend | (pr & mask);
    if (fl) begin
      if (m.kind != 3) m.ph = 1'b1;
      else if (tk)     m.ph = ~m.ph;
      m.kind = 3;
      return m;
    end
    if (m.kind == 3) begin
      m.kind = 0; m.dir = 0; m.left = A;
      return m;
    end
    if (!tk) return m;
    if (m.left > 1) begin
      m.left--;
      return m;
    end
    case (m.kind)
      0: begin
        m.kind = 1; m.left = G;
        m.walk = m.pend[m.dir];
        m.pend[m.dir] = 1'b0;
      end
      1: begin m.kind = 2; m.left = Y; end
      default: begin m.kind = 0; m.left = A; m.dir = (m.dir + 1) % n; end
    endcase
    return m;
  endfunction

  function automatic lamps_t lamps(input model_t m, input int n);
    lamps_t   l;
    bit [7:0] all = 8'((1 << n) - 1);
    bit [7:0] one = 8'(1 << m.dir);
    l.red = '0; l.green = '0; l.yellow = '0; l.walk = '0;
    l.dir = 8'(m.dir);
    case (m.kind)
      0: l.red = all;
      1: begin
        l.red = all & ~one; l.green = one;
        if (m.walk) l.walk = one;
      end
      2: begin l.red = all & ~one; l.yellow = one; end
      default: l.yellow = m.ph ? all : 8'h00;
    endcase
    return l;
  endfunction

  task automatic drive(input bit rst, input bit tk, input bit fl,
                       input bit [7:0] pr2, input bit [7:0] pr3);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    if2.tick    = tk;  if3.tick  = tk;
    if2.flash   = fl;  if3.flash = fl;
    if2.ped_req = pr2[1:0];
    if3.ped_req = pr3[2:0];
    m2 = step(m2, 2, rst, tk, fl, pr2);
    m3 = step(m3, 3, rst, tk, fl, pr3);
    e.l2 = lamps(m2, 2);
    e.l3 = lamps(m3, 3);
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("red2",    8'(if2.Red),        e.l2.red);
        check("green2",  8'(if2.Green),      e.l2.green);
        check("yellow2", 8'(if2.Yellow),     e.l2.yellow);
        check("walk2",   8'(if2.Walk),       e.l2.walk);
        check("dir2",    8'(if2.active_dir), e.l2.dir);
        check("red3",    8'(if3.Red),        e.l3.red);
        check("green3",  8'(if3.Green),      e.l3.green);
        check("yellow3", 8'(if3.Yellow),     e.l3.yellow);
        check("walk3",   8'(if3.Walk),       e.l3.walk);
        check("dir3",    8'(if3.active_dir), e.l3.dir);
      end
    end
  end

  initial begin
    bit       fl;
    bit [7:0] p2, p3;
    reset = 1'b1;
    if2.tick = 1'b0; if3.tick = 1'b0;
    if2.flash = 1'b0; if3.flash = 1'b0;
    if2.ped_req = '0; if3.ped_req = '0;
    m2 = reset_model();
    m3 = reset_model();

    // Reset with tick and flash active must still land in the reset state.
    drive(1, 1, 1, 8'h3, 8'h7);
    drive(1, 1, 0, 8'h0, 8'h0);
    @(posedge clk);
    #2;
    check("rst_red",    8'(if2.Red),        8'h03);
    check("rst_green",  8'(if2.Green),      8'h00);
    check("rst_yellow", 8'(if2.Yellow),     8'h00);
    check("rst_walk",   8'(if2.Walk),       8'h00);
    check("rst_dir",    8'(if2.active_dir), 8'h00);

    // Free run, one tick per cycle.
    repeat (30) drive(0, 1, 0, 8'h0, 8'h0);

    // Sparse timebase: tick every third cycle.
    for (int i = 0; i < 72; i++) drive(0, (i % 3) == 0, 0, 8'h0, 8'h0);

    // Pedestrian requests, including ones coincident with green entry.
    for (int i = 0; i < 120; i++) begin
      p2 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 3)) : 8'h0;
      p3 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 7)) : 8'h0;
      drive(0, 1, 0, p2, p3);
    end

    // Flash override with mixed tick density, then release.
    repeat (4) drive(0, 1, 0, 8'h0, 8'h0);
    for (int i = 0; i < 9; i++) drive(0, i[0], 1, (i == 3) ? 8'h2 : 8'h0, 8'h0);
    repeat (20) drive(0, 1, 0, 8'h0, 8'h0);

    // Reset together with flash in mid-operation.
    repeat (9) drive(0, 1, 0, 8'h0, 8'h0);
    drive(1, 1, 1, 8'h0, 8'h0);
    repeat (10) drive(0, 1, 0, 8'h0, 8'h0);

    // Long random soak.
    fl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) fl = ~fl;
      p2 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 3)) : 8'h0;
      p3 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 7)) : 8'h0;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, fl, p2, p3);
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
